// File: rtl/spi_reg_controller.sv
// Command/register sequencer behind the SPI byte shifter: parses framed read/write
// commands, owns the GPU config register bank and supplies the next transmit byte.
module spi_reg_controller #(
    parameter int          NREG     = 8,
    parameter int          ADDR_W   = 3,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic                sclk,
    input  logic                rst_n,
    input  logic                ss,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    output logic [7:0]          tx_byte,
    output logic [NREG*8-1:0]   regs_flat,
    output logic                wr_strobe,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic                busy,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DISCARD} state_t;

    localparam logic [7:0] SOFT_RESET = 8'hFF;
    localparam logic [7:0] CLEAR_ERR  = 8'h7F;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W-1:0]  addr_nx;
    logic [ADDR_W-1:0]  start;
    logic               inc;
    logic [7:0]         regs [NREG];

    // Wraps naturally because NREG is a power of two.
    assign addr_nx = addr + ADDR_W'(1);
    assign start   = rx_byte[ADDR_W-1:0];
    assign busy    = (state != IDLE);

    for (genvar i = 0; i < NREG; i++) begin : g_flat
        assign regs_flat[8*i +: 8] = regs[i];
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            inc       <= 1'b0;
            tx_byte   <= 8'h00;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            err       <= 1'b0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == 0) ? ID_VALUE : 8'h00;
        end else if (ss) begin
            // Frame end wins over a coincident byte, which is dropped.
            state     <= IDLE;
            tx_byte   <= 8'h00;
            wr_strobe <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        if (rx_byte == SOFT_RESET) begin
                            for (int i = 0; i < NREG; i++)
                                regs[i] <= (i == 0) ? ID_VALUE : 8'h00;
                            err     <= 1'b0;
                            tx_byte <= 8'h00;
                            state   <= DISCARD;
                        end else if (rx_byte == CLEAR_ERR) begin
                            err     <= 1'b0;
                            tx_byte <= 8'h00;
                            state   <= DISCARD;
                        end else if (rx_byte[5:3] != 3'b000) begin
                            err     <= 1'b1;
                            tx_byte <= 8'h00;
                            state   <= DISCARD;
                        end else begin
                            addr <= start;
                            inc  <= rx_byte[6];
                            if (rx_byte[7]) begin
                                state <= WRITE;
                            end else begin
                                tx_byte <= regs[start];
                                state   <= READ;
                            end
                        end
                    end
                    WRITE: begin
                        // Register 0 is the read-only ID; writing it is a protocol error.
                        if (addr != '0) begin
                            regs[addr] <= rx_byte;
                            wr_strobe  <= 1'b1;
                            wr_addr    <= addr;
                        end else begin
                            err <= 1'b1;
                        end
                        if (inc)
                            addr <= addr_nx;
                    end
                    READ: begin
                        if (inc) begin
                            addr    <= addr_nx;
                            tx_byte <= regs[addr_nx];
                        end else begin
                            tx_byte <= regs[addr];
                        end
                    end
                    DISCARD: tx_byte <= 8'h00;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
